tty: RTL and testbench
======================

// Module: tty
//
// PURPOSE
//   Character-output terminal sink: accepts one 8-bit ASCII byte per clock while
//   enabled is high, echoes it to the simulator console, keeps a one-line buffer
//   with cursor/column tracking, and exposes status counters. Sits at the end of
//   the CPU I/O path as the memory-mapped console device.
//
// PARAMETERS
//   LINE_WIDTH   80   characters per line before automatic wrap (2..127)
//   ECHO         1    1 = $write each accepted byte to the console (sim only)
//
// PORTS
//   clock        in   1    system clock, all state on rising edge
//   reset_n      in   1    asynchronous, active-low reset
//   data         in   8    ASCII byte to print
//   enabled      in   1    write strobe; byte accepted on every rising edge it is high
//   column       out  7    current cursor column, 0..LINE_WIDTH-1
//   char_count   out  16   bytes accepted since reset (all codes), wraps at 65535
//   line_count   out  16   completed lines (newline or wrap), wraps at 65535
//   last_char    out  8    most recently accepted byte
//   newline      out  1    one-cycle pulse in the cycle after a line completes
//
// BEHAVIOUR
//   - One clock, one async active-low reset (reset_n); all outputs are registered.
//   - Reset: column=0, char_count=0, line_count=0, last_char=8'h00, newline=0,
//     line buffer cleared to spaces (8'h20). Reset asserted mid-stream discards
//     the partial line; no console output is produced for it.
//   - Accept: enabled sampled at each rising edge; high for N edges = N bytes
//     (level, not edge detect; no back-pressure, never busy). data is don't-care
//     while enabled is low.
//   - Every accepted byte: char_count+1, last_char<=data, ECHO=1 -> $write("%c").
//   - Decode of accepted byte:
//       0x20..0x7E printable: buf[column]<=data; column+1. If column was
//         LINE_WIDTH-1: column<=0, line_count+1, newline pulse (auto-wrap).
//       0x0A LF: column<=0, line_count+1, newline pulse, buffer refilled with spaces.
//       0x0D CR: column<=0, no line increment.
//       0x08 BS: column-1 if column>0 else stays 0; buf char unchanged.
//       others: counted in char_count/last_char only; no cursor change.
//   - Latency: all outputs reflect the byte one edge after acceptance; newline
//     high for exactly one cycle; back-to-back LFs give back-to-back pulses.
//   - Counters wrap silently 16'hFFFF -> 0.
//   - Console echo under `ifndef SYNTHESIS; synthesized logic is identical with
//     ECHO=0.
//
// STRUCTURE
//   - tty_pkg: ASCII constants (ASCII_LF=8'h0A, ASCII_CR=8'h0D, ASCII_BS=8'h08,
//     ASCII_SP=8'h20, ASCII_DEL=8'h7F) and a char_class enum
//     {CC_PRINT, CC_LF, CC_CR, CC_BS, CC_OTHER} with a classify function.
//   - tty_line_buffer: LINE_WIDTH x 8 register array with write port
//     (addr, data, we) and synchronous clear-to-spaces; tty holds cursor,
//     counters and decode.
//
// TESTING
//   - Reset: pulse reset_n low mid-clock -> all outputs zero immediately,
//     no echo, buffer all 8'h20.
//   - Bytes 49..53 one per cycle, then 10 -> console prints "12345\n";
//     char_count=6, line_count=1, column=0, last_char=8'h0A, newline 1 cycle.
//   - enabled held high 3 edges with data=8'h41 -> "AAA", column=3,
//     char_count=3; enabled low with data toggling -> no change.
//   - LINE_WIDTH=4, send "ABCDE" -> wrap after 'D': line_count=1, column=1,
//     newline pulse on the wrap cycle.
//   - Send "AB", 0x08, 0x08, 0x08, 0x0D -> column 2,1,0,0,0; char_count=6.
//   - Send 0x07 and 0x7F -> column unchanged, char_count+2, last_char=8'h7F.

Source files
------------

// File: rtl/tty_pkg.sv
// Shared ASCII constants and byte classification for the tty console sink.
package tty_pkg;

  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_SP  = 8'h20;
  localparam logic [7:0] ASCII_DEL = 8'h7F;

  typedef enum logic [2:0] {
    CC_PRINT = 3'd0,
    CC_LF    = 3'd1,
    CC_CR    = 3'd2,
    CC_BS    = 3'd3,
    CC_OTHER = 3'd4
  } char_class_t;

  // DEL (0x7F) sits just above the printable range and falls into CC_OTHER.
  function automatic char_class_t classify(input logic [7:0] c);
    char_class_t cls;
    if ((c >= ASCII_SP) && (c < ASCII_DEL)) begin
      cls = CC_PRINT;
    end else begin
      case (c)
        ASCII_LF: cls = CC_LF;
        ASCII_CR: cls = CC_CR;
        ASCII_BS: cls = CC_BS;
        default:  cls = CC_OTHER;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/tty_if.sv
// Byte-write strobe and status bus between the CPU I/O path and the tty sink.
interface tty_if;

  logic [7:0]  data;
  logic        enabled;
  logic [6:0]  column;
  logic [15:0] char_count;
  logic [15:0] line_count;
  logic [7:0]  last_char;
  logic        newline;

  modport master (
    output data, enabled,
    input  column, char_count, line_count, last_char, newline
  );

  modport slave (
    input  data, enabled,
    output column, char_count, line_count, last_char, newline
  );

endinterface

// File: rtl/tty_line_buffer.sv
// One-line character store: single write port plus a synchronous clear that
// refills every cell with spaces.
module tty_line_buffer
  import tty_pkg::*;
#(
  parameter int LINE_WIDTH = 80
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  input  logic       we,
  input  logic       clr
);

  localparam logic [6:0] DEPTH = 7'(LINE_WIDTH);

  logic [7:0] mem_r [LINE_WIDTH];

  // Cell storage; clear takes priority over a same-cycle write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LINE_WIDTH; i++) mem_r[i] <= ASCII_SP;
    end else if (clr) begin
      for (int i = 0; i < LINE_WIDTH; i++) mem_r[i] <= ASCII_SP;
    end else if (we && (addr < DEPTH)) begin
      mem_r[addr] <= wdata;
    end
  end

endmodule

// File: rtl/tty.sv
// Console terminal sink: decodes each accepted byte into cursor, line and
// character counters, stores printable bytes in the line buffer.
module tty
  import tty_pkg::*;
#(
  parameter int LINE_WIDTH = 80,
  parameter bit ECHO       = 1'b1
) (
  input logic  clock,
  input logic  reset_n,
  tty_if.slave bus
);

  localparam logic [6:0] LAST_COL = 7'(LINE_WIDTH - 1);

  logic [6:0]  column_r,     column_s;
  logic [15:0] char_count_r, char_count_s;
  logic [15:0] line_count_r, line_count_s;
  logic [7:0]  last_char_r,  last_char_s;
  logic        newline_r,    newline_s;
  logic        we_s;
  logic        clr_s;
  char_class_t cls_s;

  // Next-state decode of the byte presented on this edge.
  always_comb begin
    column_s     = column_r;
    char_count_s = char_count_r;
    line_count_s = line_count_r;
    last_char_s  = last_char_r;
    newline_s    = 1'b0;
    we_s         = 1'b0;
    clr_s        = 1'b0;
    cls_s        = classify(bus.data);
    if (bus.enabled) begin
      char_count_s = char_count_r + 16'd1;
      last_char_s  = bus.data;
      case (cls_s)
        CC_PRINT: begin
          we_s = 1'b1;
          if (column_r >= LAST_COL) begin
            column_s     = 7'd0;
            line_count_s = line_count_r + 16'd1;
            newline_s    = 1'b1;
          end else begin
            column_s = column_r + 7'd1;
          end
        end
        CC_LF: begin
          column_s     = 7'd0;
          line_count_s = line_count_r + 16'd1;
          newline_s    = 1'b1;
          clr_s        = 1'b1;
        end
        CC_CR: column_s = 7'd0;
        CC_BS: begin
          if (column_r != 7'd0) begin
            column_s = column_r - 7'd1;
          end else begin
            column_s = 7'd0;
          end
        end
        CC_OTHER: column_s = column_r;
        default:  column_s = column_r;
      endcase
    end else begin
      newline_s = 1'b0;
    end
  end

  // Status registers; counters wrap naturally at 16 bits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      column_r     <= 7'd0;
      char_count_r <= 16'd0;
      line_count_r <= 16'd0;
      last_char_r  <= 8'h00;
      newline_r    <= 1'b0;
    end else begin
      column_r     <= column_s;
      char_count_r <= char_count_s;
      line_count_r <= line_count_s;
      last_char_r  <= last_char_s;
      newline_r    <= newline_s;
    end
  end

  tty_line_buffer #(.LINE_WIDTH(LINE_WIDTH)) u_buf (
    .clock   (clock),
    .reset_n (reset_n),
    .addr    (column_r),
    .wdata   (bus.data),
    .we      (we_s),
    .clr     (clr_s)
  );

  assign bus.column     = column_r;
  assign bus.char_count = char_count_r;
  assign bus.line_count = line_count_r;
  assign bus.last_char  = last_char_r;
  assign bus.newline    = newline_r;

`ifndef SYNTHESIS
  // Simulation-only console echo of every accepted byte.
  always_ff @(posedge clock) begin
    if (ECHO && reset_n && bus.enabled) $write("%c", bus.data);
  end
`endif

endmodule

// File: tb/tb_tty.sv
// Bench for tty: table-driven byte stream with a scoreboard queue on the
// 80-column instance, plus hand sequences for reset and 4-column wrap.
module tb_tty;

  logic clock;
  logic reset_n;
  int   tests  = 0;
  int   fails  = 0;

  tty_if bus_a ();
  tty_if bus_b ();

  tty #(.LINE_WIDTH(80), .ECHO(1'b1)) u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_a)
  );

  tty #(.LINE_WIDTH(4), .ECHO(1'b0)) u_dut4 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        en;
    logic [7:0]  data;
    logic [6:0]  col;
    logic [15:0] cc;
    logic [15:0] lc;
    logic [7:0]  last;
    logic        nl;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic vec_t mk(input logic en, input logic [7:0] d, input logic [6:0] col,
                              input logic [15:0] cc, input logic [15:0] lc,
                              input logic [7:0] last, input logic nl);
    vec_t v;
    v.en = en; v.data = d; v.col = col; v.cc = cc; v.lc = lc; v.last = last; v.nl = nl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("\nFAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_check(input int idx);
    vec_t e;
    e = sb.pop_front();
    chk($sformatf("v%0d column", idx),     {9'd0, bus_a.column},   {9'd0, e.col});
    chk($sformatf("v%0d char_count", idx), bus_a.char_count,        e.cc);
    chk($sformatf("v%0d line_count", idx), bus_a.line_count,        e.lc);
    chk($sformatf("v%0d last_char", idx),  {8'd0, bus_a.last_char}, {8'd0, e.last});
    chk($sformatf("v%0d newline", idx),    {15'd0, bus_a.newline},  {15'd0, e.nl});
  endtask

  task automatic step4(input logic [7:0] d, input logic [6:0] col, input logic [15:0] lc,
                       input logic nl);
    @(negedge clock);
    bus_b.enabled = 1'b1;
    bus_b.data    = d;
    @(negedge clock);
    bus_b.enabled = 1'b0;
    chk($sformatf("w4 %c column", d),  {9'd0, bus_b.column},  {9'd0, col});
    chk($sformatf("w4 %c line", d),    bus_b.line_count,       lc);
    chk($sformatf("w4 %c newline", d), {15'd0, bus_b.newline}, {15'd0, nl});
  endtask

  initial begin
    reset_n       = 1'b0;
    bus_a.enabled = 1'b0;
    bus_a.data    = 8'h00;
    bus_b.enabled = 1'b0;
    bus_b.data    = 8'h00;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Partial line then a mid-clock reset: everything must clear at once.
    @(negedge clock); bus_a.enabled = 1'b1; bus_a.data = 8'h78;
    @(negedge clock); bus_a.data = 8'h0A;
    @(negedge clock); bus_a.data = 8'h79;
    @(negedge clock); bus_a.enabled = 1'b0;
    chk("pre-reset char_count", bus_a.char_count, 16'd3);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("rst column",     {9'd0, bus_a.column},   16'd0);
    chk("rst char_count", bus_a.char_count,        16'd0);
    chk("rst line_count", bus_a.line_count,        16'd0);
    chk("rst last_char",  {8'd0, bus_a.last_char}, 16'd0);
    chk("rst newline",    {15'd0, bus_a.newline},  16'd0);
    chk("rst buf0",       {8'd0, u_dut.u_buf.mem_r[0]}, 16'h0020);
    chk("rst buf79",      {8'd0, u_dut.u_buf.mem_r[79]}, 16'h0020);
    @(negedge clock);
    reset_n = 1'b1;

    // en, data, column, char_count, line_count, last_char, newline
    vecs.push_back(mk(1'b1, 8'h31, 7'd1, 16'd1,  16'd0, 8'h31, 1'b0));
    vecs.push_back(mk(1'b1, 8'h32, 7'd2, 16'd2,  16'd0, 8'h32, 1'b0));
    vecs.push_back(mk(1'b1, 8'h33, 7'd3, 16'd3,  16'd0, 8'h33, 1'b0));
    vecs.push_back(mk(1'b1, 8'h34, 7'd4, 16'd4,  16'd0, 8'h34, 1'b0));
    vecs.push_back(mk(1'b1, 8'h35, 7'd5, 16'd5,  16'd0, 8'h35, 1'b0));
    vecs.push_back(mk(1'b1, 8'h0A, 7'd0, 16'd6,  16'd1, 8'h0A, 1'b1));
    vecs.push_back(mk(1'b0, 8'h55, 7'd0, 16'd6,  16'd1, 8'h0A, 1'b0));
    vecs.push_back(mk(1'b1, 8'h41, 7'd1, 16'd7,  16'd1, 8'h41, 1'b0));
    vecs.push_back(mk(1'b1, 8'h41, 7'd2, 16'd8,  16'd1, 8'h41, 1'b0));
    vecs.push_back(mk(1'b1, 8'h41, 7'd3, 16'd9,  16'd1, 8'h41, 1'b0));
    vecs.push_back(mk(1'b0, 8'h33, 7'd3, 16'd9,  16'd1, 8'h41, 1'b0));
    vecs.push_back(mk(1'b0, 8'h0A, 7'd3, 16'd9,  16'd1, 8'h41, 1'b0));
    vecs.push_back(mk(1'b0, 8'h08, 7'd3, 16'd9,  16'd1, 8'h41, 1'b0));
    vecs.push_back(mk(1'b1, 8'h0D, 7'd0, 16'd10, 16'd1, 8'h0D, 1'b0));
    vecs.push_back(mk(1'b1, 8'h41, 7'd1, 16'd11, 16'd1, 8'h41, 1'b0));
    vecs.push_back(mk(1'b1, 8'h42, 7'd2, 16'd12, 16'd1, 8'h42, 1'b0));
    vecs.push_back(mk(1'b1, 8'h08, 7'd1, 16'd13, 16'd1, 8'h08, 1'b0));
    vecs.push_back(mk(1'b1, 8'h08, 7'd0, 16'd14, 16'd1, 8'h08, 1'b0));
    vecs.push_back(mk(1'b1, 8'h08, 7'd0, 16'd15, 16'd1, 8'h08, 1'b0));
    vecs.push_back(mk(1'b1, 8'h0D, 7'd0, 16'd16, 16'd1, 8'h0D, 1'b0));
    vecs.push_back(mk(1'b1, 8'h07, 7'd0, 16'd17, 16'd1, 8'h07, 1'b0));
    vecs.push_back(mk(1'b1, 8'h7F, 7'd0, 16'd18, 16'd1, 8'h7F, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      if (sb.size() > 0) pop_check(i - 1);
      bus_a.enabled = vecs[i].en;
      bus_a.data    = vecs[i].data;
      sb.push_back(vecs[i]);
    end
    @(negedge clock);
    pop_check(vecs.size() - 1);
    bus_a.enabled = 1'b0;

    // Backspace leaves stored characters intact: "AB" over "AAA".
    chk("buf0 after AB", {8'd0, u_dut.u_buf.mem_r[0]}, 16'h0041);
    chk("buf1 after AB", {8'd0, u_dut.u_buf.mem_r[1]}, 16'h0042);
    chk("buf2 after AB", {8'd0, u_dut.u_buf.mem_r[2]}, 16'h0041);
    chk("buf3 after AB", {8'd0, u_dut.u_buf.mem_r[3]}, 16'h0020);

    // Back-to-back LFs: two consecutive pulses, then low.
    @(negedge clock); bus_a.enabled = 1'b1; bus_a.data = 8'h0A;
    @(negedge clock);
    chk("lf1 newline", {15'd0, bus_a.newline}, 16'd1);
    chk("lf1 line",    bus_a.line_count,       16'd2);
    @(negedge clock); bus_a.enabled = 1'b0;
    chk("lf2 newline", {15'd0, bus_a.newline}, 16'd1);
    chk("lf2 line",    bus_a.line_count,       16'd3);
    chk("lf2 count",   bus_a.char_count,       16'd20);
    @(negedge clock);
    chk("lf idle newline", {15'd0, bus_a.newline}, 16'd0);
    chk("buf0 cleared", {8'd0, u_dut.u_buf.mem_r[0]}, 16'h0020);
    chk("buf2 cleared", {8'd0, u_dut.u_buf.mem_r[2]}, 16'h0020);

    // Auto-wrap on the 4-column instance: "ABCDE".
    step4(8'h41, 7'd1, 16'd0, 1'b0);
    step4(8'h42, 7'd2, 16'd0, 1'b0);
    step4(8'h43, 7'd3, 16'd0, 1'b0);
    step4(8'h44, 7'd0, 16'd1, 1'b1);
    step4(8'h45, 7'd1, 16'd1, 1'b0);
    chk("w4 char_count", bus_b.char_count, 16'd5);
    chk("w4 buf0", {8'd0, u_dut4.u_buf.mem_r[0]}, 16'h0045);
    chk("w4 buf3", {8'd0, u_dut4.u_buf.mem_r[3]}, 16'h0044);

    $write("\n");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
